rst_seq_ctrl: RTL and testbench

Reset sequencer that drives the design's active-low domain resets, the generating end of each downstream reset synchronizer. It asserts all domain resets immediately on power-on reset or a software reset request, holds them for a stretch period, then releases them one domain at a time in index order. Software requests use a four-phase req/ack handshake, typically driven from a JTAG-accessible control register.

---
 rtl/rst_seq_ctrl_pkg.sv | 25 ++
 rtl/rst_seq_ctrl_rst_sync.sv | 22 ++
 rtl/rst_seq_ctrl.sv | 133 +++++++++++++
 tb/tb_rst_seq_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_ctrl_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package rst_seq_ctrl_pkg;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_STRETCH = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } seq_state_e;

  // The cycle counter has to hold the larger of the two delays, plus one.
  function automatic int unsigned cnt_width(input int unsigned stretch_cycles,
                                            input int unsigned stage_gap);
    int unsigned longest;
    longest = (stretch_cycles > stage_gap) ? stretch_cycles : stage_gap;
    return $clog2(longest + 1);
  endfunction

  // Stage index width, kept at one bit or more so a single-domain build still
  // has a legal vector.
  function automatic int unsigned idx_width(input int unsigned num_domains);
    return (num_domains <= 2) ? 1 : $clog2(num_domains);
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_rst_sync.sv
// Two-flop active-low reset synchronizer: asserts asynchronously, releases
// on the second clk edge after rst_n rises.
module rst_seq_ctrl_rst_sync (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync_n
);

  logic meta_n;

  // Shift a constant one through two flops; rst_n clears both at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_n     <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      meta_n     <= 1'b1;
      rst_sync_n <= meta_n;
    end
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds every domain reset low for a stretch period after
// power-on or a software request, then releases the domains one at a time
// from bit 0 upward.
//
// sw_rst_req / sw_rst_ack is a four-phase handshake: the requester raises req
// and holds it; ack rises on the edge the request is accepted (only in DONE
// and only while ack is low); ack falls on the first edge that samples req
// low, whatever the sequencer is doing; a new request needs ack low first.
module rst_seq_ctrl
  import rst_seq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS    = 3,
  parameter int unsigned STRETCH_CYCLES = 16,
  parameter int unsigned STAGE_GAP      = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sw_rst_req,
  output logic                   sw_rst_ack,
  output logic [NUM_DOMAINS-1:0] rst_out_n,
  output logic                   seq_busy,
  output logic                   seq_done
);

  localparam int unsigned CNT_W = cnt_width(STRETCH_CYCLES, STAGE_GAP);
  localparam int unsigned IDX_W = idx_width(NUM_DOMAINS);

  localparam logic [CNT_W-1:0]       STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0]       GAP_LAST     = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0]       LAST_IDX     = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [NUM_DOMAINS-1:0] LSB_ONE      = NUM_DOMAINS'(1);

  logic             rst_int_n;
  seq_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic             accept;

  rst_seq_ctrl_rst_sync u_rst_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .rst_sync_n (rst_int_n)
  );

  // Next domain to release and the request-acceptance condition.
  always_comb begin
    idx_nxt = idx + 1'b1;
    accept  = (state == ST_DONE) && sw_rst_req && !sw_rst_ack;
  end

  // Acknowledge: set on acceptance, cleared on the first edge that sees req low.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sw_rst_ack <= 1'b0;
    end else if (accept) begin
      sw_rst_ack <= 1'b1;
    end else if (sw_rst_ack && !sw_rst_req) begin
      sw_rst_ack <= 1'b0;
    end
  end

  // Sequencer FSM: stretch, staged release (thermometer fill from bit 0), done.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state     <= ST_STRETCH;
      cnt       <= '0;
      idx       <= '0;
      rst_out_n <= '0;
      seq_busy  <= 1'b1;
      seq_done  <= 1'b0;
    end else begin
      case (state)
        ST_STRETCH: begin
          if (cnt == STRETCH_LAST) begin
            // The stretch ends on the same edge that releases domain 0.
            cnt       <= '0;
            idx       <= '0;
            rst_out_n <= (rst_out_n << 1) | LSB_ONE;
            if (NUM_DOMAINS == 1) begin
              state    <= ST_DONE;
              seq_busy <= 1'b0;
              seq_done <= 1'b1;
            end else begin
              state <= ST_RELEASE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_RELEASE: begin
          // idx is the most recently released domain; wait out the gap, then
          // release the next one.
          if (cnt == GAP_LAST) begin
            cnt       <= '0;
            idx       <= idx_nxt;
            rst_out_n <= (rst_out_n << 1) | LSB_ONE;
            if (idx_nxt == LAST_IDX) begin
              state    <= ST_DONE;
              seq_busy <= 1'b0;
              seq_done <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DONE: begin
          if (accept) begin
            state     <= ST_STRETCH;
            cnt       <= '0;
            idx       <= '0;
            rst_out_n <= '0;
            seq_busy  <= 1'b1;
            seq_done  <= 1'b0;
          end
        end

        default: begin
          // Unreachable encoding: fall back into a full reset sequence.
          state     <= ST_STRETCH;
          cnt       <= '0;
          idx       <= '0;
          rst_out_n <= '0;
          seq_busy  <= 1'b1;
          seq_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: a default instance (3 domains, 16/4) and a corner
// instance (1 domain, 1/1) driven side by side against a timing model.
module tb_rst_seq_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_n_v = 2'b11;
  logic [1:0] req_v   = 2'b00;

  logic [2:0] out_a;
  logic [0:0] out_b;
  logic       ack_a, ack_b, busy_a, busy_b, done_a, done_b;

  int errors = 0;
  int checks = 0;

  rst_seq_ctrl #(.NUM_DOMAINS(3), .STRETCH_CYCLES(16), .STAGE_GAP(4)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n_v[0]),
    .sw_rst_req (req_v[0]),
    .sw_rst_ack (ack_a),
    .rst_out_n  (out_a),
    .seq_busy   (busy_a),
    .seq_done   (done_a)
  );

  rst_seq_ctrl #(.NUM_DOMAINS(1), .STRETCH_CYCLES(1), .STAGE_GAP(1)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n_v[1]),
    .sw_rst_req (req_v[1]),
    .sw_rst_ack (ack_b),
    .rst_out_n  (out_b),
    .seq_busy   (busy_b),
    .seq_done   (done_b)
  );

  // ---------------- reference model ----------------
  // Each instance is described by edges since its sequence began (t): domain
  // i is released once t >= S + i*G, and the sequence is done once the last
  // domain is released. sync_c counts clean edges since rst_n rose.
  int pn[2] = '{3, 1};
  int ps[2] = '{16, 1};
  int pg[2] = '{4, 1};
  int sync_c[2];
  int t[2];
  bit ack_m[2];

  function automatic void model_reset(input int d);
    sync_c[d] = 0;
    t[d]      = 0;
    ack_m[d]  = 1'b0;
  endfunction

  function automatic bit synced(input int d);
    return sync_c[d] >= 2;
  endfunction

  function automatic int seq_len(input int d);
    return ps[d] + (pn[d] - 1) * pg[d];
  endfunction

  function automatic bit exp_done(input int d);
    return synced(d) && (t[d] >= seq_len(d));
  endfunction

  function automatic logic [31:0] exp_rst(input int d);
    logic [31:0] v;
    v = '0;
    if (synced(d))
      for (int i = 0; i < pn[d]; i++)
        if (t[d] >= ps[d] + i * pg[d]) v[i] = 1'b1;
    return v;
  endfunction

  function automatic void model_edge(input int d);
    bit acc;
    if (!rst_n_v[d]) begin
      model_reset(d);
    end else if (!synced(d)) begin
      sync_c[d]++;
      t[d] = 0;
    end else begin
      acc = exp_done(d) && req_v[d] && !ack_m[d];
      if (acc) begin
        ack_m[d] = 1'b1;
        t[d]     = 0;
      end else begin
        if (ack_m[d] && !req_v[d]) ack_m[d] = 1'b0;
        if (t[d] <= seq_len(d)) t[d]++;
      end
    end
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs_rst(input int d);
    return (d == 0) ? 32'(out_a) : 32'(out_b);
  endfunction
  function automatic logic [31:0] obs_ack(input int d);
    return (d == 0) ? 32'(ack_a) : 32'(ack_b);
  endfunction
  function automatic logic [31:0] obs_busy(input int d);
    return (d == 0) ? 32'(busy_a) : 32'(busy_b);
  endfunction
  function automatic logic [31:0] obs_done(input int d);
    return (d == 0) ? 32'(done_a) : 32'(done_b);
  endfunction

  task automatic compare_all();
    string s;
    for (int d = 0; d < 2; d++) begin
      s = (d == 0) ? "a" : "b";
      check({s, "_rst_out_n"}, obs_rst(d), exp_rst(d));
      check({s, "_ack"}, obs_ack(d), 32'(ack_m[d]));
      check({s, "_busy"}, obs_busy(d), 32'(!exp_done(d)));
      check({s, "_done"}, obs_done(d), 32'(exp_done(d)));
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: advance the model on the rising edge, compare on the falling.
  task automatic step();
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_edge(d);
    @(negedge clk);
    compare_all();
  endtask

  // Pulse rst_n low between edges; outputs must clear without a clock. Returns
  // at a falling edge with rst_n high again (the following rising edge is the
  // first edge seen by the synchronizer).
  task automatic async_reset(input int d);
    rst_n_v[d] = 1'b0;
    #1;
    model_reset(d);
    check("async_rst_out", obs_rst(d), 32'd0);
    compare_all();
    step();
    rst_n_v[d] = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 rst_n_v = 2'b00;
    for (int d = 0; d < 2; d++) model_reset(d);
    for (int k = 0; k < 3; k++) step();
    check("por_rst_out_a", 32'(out_a), 32'd0);
    check("por_busy_a", 32'(busy_a), 32'd1);
    rst_n_v = 2'b11;

    // Power-on release timing.
    for (int k = 1; k <= 26; k++) begin
      step();
      if (k == 2)  check("b_po_e2", 32'(out_b), 32'd0);
      if (k == 3)  check("b_po_e3_out", 32'(out_b), 32'd1);
      if (k == 3)  check("b_po_e3_done", 32'(done_b), 32'd1);
      if (k == 17) check("po_e17", 32'(out_a), 32'd0);
      if (k == 18) check("po_e18", 32'(out_a), 32'd1);
      if (k == 22) check("po_e22", 32'(out_a), 32'd3);
      if (k == 25) check("po_e25_done", 32'(done_a), 32'd0);
      if (k == 26) check("po_e26", 32'(out_a), 32'd7);
      if (k == 26) check("po_e26_done", 32'(done_a), 32'd1);
      if (k == 26) check("po_e26_busy", 32'(busy_a), 32'd0);
    end

    // Software reset from DONE on both instances.
    req_v = 2'b11;
    for (int k = 0; k <= 24; k++) begin
      step();
      if (k == 0)  check("sw_e_ack", 32'(ack_a), 32'd1);
      if (k == 0)  check("sw_e_out", 32'(out_a), 32'd0);
      if (k == 5)  check("sw_e5_ack", 32'(ack_a), 32'd1);
      if (k == 6)  check("sw_e6_ack", 32'(ack_a), 32'd0);
      if (k == 15) check("sw_e15", 32'(out_a), 32'd0);
      if (k == 16) check("sw_e16", 32'(out_a), 32'd1);
      if (k == 20) check("sw_e20", 32'(out_a), 32'd3);
      if (k == 24) check("sw_e24", 32'(out_a), 32'd7);
      if (k == 1)  check("b_sw_e1", 32'(out_b), 32'd1);
      if (k == 4)  check("b_no_rearm_ack", 32'(ack_b), 32'd1);
      if (k == 4)  check("b_no_rearm_done", 32'(done_b), 32'd1);
      if (k == 9)  check("b_ack_drop", 32'(ack_b), 32'd0);
      if (k == 11) check("b_rearm_out", 32'(out_b), 32'd0);
      if (k == 11) check("b_rearm_ack", 32'(ack_b), 32'd1);
      if (k == 12) check("b_rearm_rel", 32'(out_b), 32'd1);
      if (k == 5)  req_v[0] = 1'b0;
      if (k == 8)  req_v[1] = 1'b0;
      if (k == 10) req_v[1] = 1'b1;
      if (k == 13) req_v[1] = 1'b0;
    end

    // Request held while busy after power-on.
    async_reset(0);
    for (int k = 1; k <= 51; k++) begin
      step();
      if (k == 6)  req_v[0] = 1'b1;
      if (k == 20) check("busy_req_ack", 32'(ack_a), 32'd0);
      if (k == 26) check("busy_e26_ack", 32'(ack_a), 32'd0);
      if (k == 27) check("busy_e27_ack", 32'(ack_a), 32'd1);
      if (k == 27) check("busy_e27_out", 32'(out_a), 32'd0);
      if (k == 30) req_v[0] = 1'b0;
      if (k == 31) check("busy_ack_drop", 32'(ack_a), 32'd0);
      if (k == 51) check("busy_second_seq", 32'(out_a), 32'd7);
    end

    // Mid-sequence async reset, then the full power-on timing again.
    async_reset(0);
    for (int k = 1; k <= 19; k++) begin
      step();
      if (k == 18) check("mid_bit0", 32'(out_a), 32'd1);
    end
    async_reset(0);
    for (int k = 1; k <= 26; k++) begin
      step();
      if (k == 17) check("re_po_e17", 32'(out_a), 32'd0);
      if (k == 18) check("re_po_e18", 32'(out_a), 32'd1);
      if (k == 26) check("re_po_e26", 32'(out_a), 32'd7);
    end

    // Reset coinciding with a request on the corner instance.
    req_v[1] = 1'b1;
    async_reset(1);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 3) check("b_rst_req_rel", 32'(out_b), 32'd1);
      if (k == 4) check("b_rst_req_acc", 32'(ack_b), 32'd1);
    end
    req_v[1] = 1'b0;

    // Randomized requests and occasional async resets.
    for (int n = 0; n < 3000; n++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 7) == 0) req_v[d] = ~req_v[d];
        if ($urandom_range(0, 399) == 0) async_reset(d);
      end
    end

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
